// File: rtl/lpr_pkg.sv
// lpr_pkg: shared FSM state type, coordinate width and parameter defaults for the plate box detector
package lpr_pkg;
  localparam int CW = 12;
  localparam int B_MIN_DEF = 100;
  localparam int DIFF_MIN_DEF = 40;
  localparam int ROW_MIN_CNT_DEF = 20;
  localparam int MIN_HEIGHT_DEF = 8;
  typedef enum logic [1:0] {IDLE, SCAN, MERGE, PUBLISH} state_t;
endpackage

// File: rtl/lpr_row_accum.sv
// lpr_row_accum: per-row candidate count (saturating) with min/max candidate column and row number
module lpr_row_accum
  import lpr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cand_i,
  input  logic          clr_i,
  input  logic [CW-1:0] hcount_i,
  input  logic [CW-1:0] vcount_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] hmin_o,
  output logic [CW-1:0] hmax_o,
  output logic [CW-1:0] vrow_o
);
  logic [CW-1:0] cnt_q, hmin_q, hmax_q, vrow_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q  <= '0;
      hmin_q <= '1;
      hmax_q <= '0;
      vrow_q <= '0;
    end else if (cand_i) begin
      cnt_q  <= cnt_q + CW'(cnt_q != '1);
      hmin_q <= hcount_i < hmin_q ? hcount_i : hmin_q;
      hmax_q <= hcount_i > hmax_q ? hcount_i : hmax_q;
      vrow_q <= vcount_i;
    end
  end
  assign cnt_o  = cnt_q;
  assign hmin_o = hmin_q;
  assign hmax_o = hmax_q;
  assign vrow_o = vrow_q;
endmodule

// File: rtl/lpr_boundary_detect.sv
// lpr_boundary_detect: accumulates the bounding box of rows rich in blue pixels and publishes it once per frame
module lpr_boundary_detect
  import lpr_pkg::*;
#(
  parameter int B_MIN       = B_MIN_DEF,
  parameter int DIFF_MIN    = DIFF_MIN_DEF,
  parameter int ROW_MIN_CNT = ROW_MIN_CNT_DEF,
  parameter int MIN_HEIGHT  = MIN_HEIGHT_DEF
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic [23:0]   i_rgb,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  output logic [CW-1:0] hcount_l,
  output logic [CW-1:0] hcount_r,
  output logic [CW-1:0] vcount_l,
  output logic [CW-1:0] vcount_r,
  output logic [CW-1:0] h2,
  output logic [CW-1:0] v3,
  output logic [CW-1:0] v5,
  output logic          box_valid,
  output logic          frame_done
);
  localparam logic [7:0]    BMIN = 8'(B_MIN);
  localparam logic [7:0]    DMIN = 8'(DIFF_MIN);
  localparam logic [CW-1:0] RMIN = CW'(ROW_MIN_CNT);
  localparam logic [CW-1:0] HMIN = CW'(MIN_HEIGHT);
  state_t state_q, state_d;
  logic de_q, vs_q, vs_qq, row_end, vs_rise, cand, unused_ok;
  logic [7:0] r, g, b, dr, dg;
  logic [CW-1:0] cnt, rmin, rmax, rrow;
  logic pend_q, any_q, any_m, ok;
  logic [CW-1:0] pv_q, pmin_q, pmax_q, top_q, bot_q, lft_q, rgt_q;
  logic [CW-1:0] top_m, bot_m, lft_m, rgt_m, ht, qt;
  logic [CW:0] hsum;
  assign {r, g, b} = i_rgb;
  assign dr = b - r;
  assign dg = b - g;
  assign cand = i_de && state_q == SCAN && b >= BMIN && b > r && b > g && dr >= DMIN && dg >= DMIN;
  assign row_end = de_q && !i_de;
  assign vs_rise = vs_q && !vs_qq;
  assign unused_ok = i_hsync;
  assign frame_done = state_q == PUBLISH;
  lpr_row_accum u_row (
    .clk(pixelclk), .rst(reset), .cand_i(cand), .clr_i(row_end),
    .hcount_i(hcount), .vcount_i(vcount),
    .cnt_o(cnt), .hmin_o(rmin), .hmax_o(rmax), .vrow_o(rrow)
  );
  always_comb begin
    state_d = state_q == IDLE  ? (vs_rise ? SCAN : IDLE) :
              state_q == SCAN  ? (vs_rise ? MERGE : SCAN) :
              state_q == MERGE ? PUBLISH : SCAN;
  end
  // merged view of the frame box including any row still pending, so a row ending with the frame is not lost
  always_comb begin
    any_m = any_q || pend_q;
    top_m = pend_q && (!any_q || pv_q < top_q) ? pv_q : top_q;
    bot_m = pend_q && (!any_q || pv_q > bot_q) ? pv_q : bot_q;
    lft_m = pend_q && (!any_q || pmin_q < lft_q) ? pmin_q : lft_q;
    rgt_m = pend_q && (!any_q || pmax_q > rgt_q) ? pmax_q : rgt_q;
    ht = bot_m - top_m;
    qt = ht >> 2;
    hsum = {1'b0, lft_m} + {1'b0, rgt_m};
    ok = any_m && ht >= HMIN;
  end
  always_ff @(posedge pixelclk) begin
    state_q <= reset ? IDLE : state_d;
  end
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      de_q  <= 1'b0;
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      de_q  <= i_de;
      vs_q  <= i_vsync;
      vs_qq <= vs_q;
    end
  end
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      pend_q <= 1'b0;
      pv_q   <= '0;
      pmin_q <= '0;
      pmax_q <= '0;
    end else begin
      pend_q <= state_q == SCAN && row_end && cnt >= RMIN;
      pv_q   <= rrow;
      pmin_q <= rmin;
      pmax_q <= rmax;
    end
  end
  always_ff @(posedge pixelclk) begin
    if (reset || state_q == PUBLISH || state_q == IDLE) begin
      any_q <= 1'b0;
      top_q <= '0;
      bot_q <= '0;
      lft_q <= '0;
      rgt_q <= '0;
    end else begin
      any_q <= any_m;
      top_q <= top_m;
      bot_q <= bot_m;
      lft_q <= lft_m;
      rgt_q <= rgt_m;
    end
  end
  // outputs load leaving MERGE so they are already valid while frame_done is high
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      hcount_l  <= '0;
      hcount_r  <= '0;
      vcount_l  <= '0;
      vcount_r  <= '0;
      h2        <= '0;
      v3        <= '0;
      v5        <= '0;
      box_valid <= 1'b0;
    end else if (state_q == MERGE) begin
      hcount_l  <= ok ? lft_m : '0;
      hcount_r  <= ok ? rgt_m : '0;
      vcount_l  <= ok ? top_m : '0;
      vcount_r  <= ok ? bot_m : '0;
      h2        <= ok ? hsum[CW:1] : '0;
      v3        <= ok ? top_m + qt : '0;
      v5        <= ok ? bot_m - qt : '0;
      box_valid <= ok;
    end
  end
endmodule

// File: tb/tb_lpr_boundary_detect.sv
// tb_lpr_boundary_detect: directed and random frames checked against an image-level box model
module tb_lpr_boundary_detect;
  localparam logic [23:0] BLUE = {8'd20, 8'd30, 8'd200};
  logic pixelclk = 1'b0, reset = 1'b1, i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
  logic [23:0] i_rgb = '0;
  logic [11:0] hcount = '0, vcount = '0;
  logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r, h2, v3, v5;
  logic box_valid, frame_done;
  int n_chk = 0, n_bad = 0;
  int fv0, fh0, nr, nc;
  logic [23:0] img [0:47][0:167];
  int exp_l, exp_r, exp_t, exp_b, exp_h2, exp_v3, exp_v5, exp_ok;
  int pub_l, pub_r, pub_t, pub_b, pub_h2, pub_v3, pub_v5, pub_ok;
  bit scanning = 1'b0;
  always #5 pixelclk = ~pixelclk;
  lpr_boundary_detect dut (
    .pixelclk(pixelclk), .reset(reset), .i_rgb(i_rgb), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_de(i_de), .hcount(hcount), .vcount(vcount), .hcount_l(hcount_l), .hcount_r(hcount_r),
    .vcount_l(vcount_l), .vcount_r(vcount_r), .h2(h2), .v3(v3), .v5(v5),
    .box_valid(box_valid), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic tick;
    @(posedge pixelclk);
    #1;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".hl"}, int'(hcount_l), pub_l);
    chk({tag, ".hr"}, int'(hcount_r), pub_r);
    chk({tag, ".vl"}, int'(vcount_l), pub_t);
    chk({tag, ".vr"}, int'(vcount_r), pub_b);
    chk({tag, ".h2"}, int'(h2), pub_h2);
    chk({tag, ".v3"}, int'(v3), pub_v3);
    chk({tag, ".v5"}, int'(v5), pub_v5);
    chk({tag, ".valid"}, int'(box_valid), pub_ok);
  endtask
  task automatic set_exp(input int l, r, t, b, hc, a, c, ok);
    exp_l = l; exp_r = r; exp_t = t; exp_b = b; exp_h2 = hc; exp_v3 = a; exp_v5 = c; exp_ok = ok;
  endtask
  task automatic clear_pub;
    pub_l = 0; pub_r = 0; pub_t = 0; pub_b = 0; pub_h2 = 0; pub_v3 = 0; pub_v5 = 0; pub_ok = 0;
  endtask
  function automatic bit is_cand(input logic [23:0] px);
    int r = int'(px[23:16]);
    int g = int'(px[15:8]);
    int b = int'(px[7:0]);
    return b >= 100 && b > r && b > g && b - r >= 40 && b - g >= 40;
  endfunction
  task automatic set_win(input int v, h, r, c);
    fv0 = v; fh0 = h; nr = r; nc = c;
    for (int i = 0; i < 48; i++)
      for (int j = 0; j < 168; j++) img[i][j] = '0;
  endtask
  task automatic rect(input int v_lo, v_hi, h_lo, h_hi, input logic [23:0] px);
    for (int v = v_lo; v <= v_hi; v++)
      for (int h = h_lo; h <= h_hi; h++) img[v - fv0][h - fh0] = px;
  endtask
  task automatic model;
    bit any = 1'b0;
    int t = 0, bt = 0, l = 0, rr = 0;
    for (int i = 0; i < nr; i++) begin
      int cnt = 0, mn = 4096, mx = -1;
      for (int j = 0; j < nc; j++)
        if (is_cand(img[i][j])) begin
          cnt++;
          if (fh0 + j < mn) mn = fh0 + j;
          if (fh0 + j > mx) mx = fh0 + j;
        end
      if (cnt >= 20) begin
        if (!any || fv0 + i < t) t = fv0 + i;
        if (!any || fv0 + i > bt) bt = fv0 + i;
        if (!any || mn < l) l = mn;
        if (!any || mx > rr) rr = mx;
        any = 1'b1;
      end
    end
    if (any && bt - t >= 8) set_exp(l, rr, t, bt, (l + rr) / 2, t + (bt - t) / 4, bt - (bt - t) / 4, 1);
    else set_exp(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic drive_frame(input int rst_row, input bit tight);
    for (int i = 0; i < nr; i++) begin
      if (fv0 + i == rst_row) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        clear_pub;
        check_outs("rst_mid");
        chk("rst_mid.fd", int'(frame_done), 0);
        scanning = 1'b0;
      end
      for (int j = 0; j < nc; j++) begin
        i_de = 1'b1; hcount = 12'(fh0 + j); vcount = 12'(fv0 + i); i_rgb = img[i][j];
        tick;
      end
      i_de = 1'b0; i_rgb = '0;
      if (!(tight && i == nr - 1)) begin
        i_hsync = 1'b1;
        repeat (3) tick;
        i_hsync = 1'b0;
      end
    end
  endtask
  task automatic frame_end;
    check_outs("hold");
    i_de = 1'b0; i_vsync = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("frame_done", int'(frame_done), (scanning && k == 2) ? 1 : 0);
    end
    if (scanning) begin
      pub_l = exp_l; pub_r = exp_r; pub_t = exp_t; pub_b = exp_b;
      pub_h2 = exp_h2; pub_v3 = exp_v3; pub_v5 = exp_v5; pub_ok = exp_ok;
    end
    scanning = 1'b1;
    check_outs("pub");
    i_vsync = 1'b0;
    repeat (2) tick;
  endtask
  initial begin
    int p, r, g, b;
    clear_pub;
    repeat (3) tick;
    check_outs("reset");
    chk("reset.fd", int'(frame_done), 0);
    reset = 1'b0;
    tick;
    set_win(100, 100, 12, 30);
    rect(100, 111, 100, 129, BLUE);
    drive_frame(-1, 1'b0);
    frame_end;
    set_win(298, 196, 44, 168);
    rect(300, 339, 200, 359, BLUE);
    drive_frame(-1, 1'b0);
    set_exp(200, 359, 300, 339, 279, 309, 330, 1);
    frame_end;
    set_win(300, 200, 12, 40);
    drive_frame(-1, 1'b0);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    frame_end;
    set_win(300, 196, 5, 168);
    rect(300, 304, 200, 359, BLUE);
    drive_frame(-1, 1'b0);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    frame_end;
    set_win(296, 196, 20, 168);
    rect(300, 311, 220, 259, BLUE);
    rect(298, 298, 196, 214, BLUE);
    rect(313, 313, 340, 359, BLUE);
    drive_frame(-1, 1'b0);
    set_exp(220, 359, 300, 313, 289, 303, 310, 1);
    frame_end;
    set_win(300, 200, 12, 40);
    rect(300, 309, 200, 219, {8'd160, 8'd30, 8'd200});
    rect(310, 310, 200, 224, {8'd161, 8'd30, 8'd200});
    rect(311, 311, 200, 224, {8'd0, 8'd0, 8'd99});
    drive_frame(-1, 1'b0);
    set_exp(200, 219, 300, 309, 209, 302, 307, 1);
    frame_end;
    set_win(298, 196, 44, 168);
    rect(300, 339, 200, 359, BLUE);
    drive_frame(320, 1'b0);
    frame_end;
    drive_frame(-1, 1'b0);
    set_exp(200, 359, 300, 339, 279, 309, 330, 1);
    frame_end;
    for (int k = 0; k < 8; k++) begin
      set_win($urandom_range(0, 4000), $urandom_range(0, 4000), $urandom_range(4, 24), $urandom_range(24, 64));
      for (int i = 0; i < nr; i++) begin
        p = $urandom_range(0, 100);
        for (int j = 0; j < nc; j++)
          if ($urandom_range(0, 99) < p) begin
            b = $urandom_range(90, 255);
            r = $urandom_range(0, b);
            g = $urandom_range(0, b);
            img[i][j] = {8'(r), 8'(g), 8'(b)};
          end else img[i][j] = 24'($urandom);
      end
      if (k % 2 == 1)
        for (int j = 0; j < nc; j++) img[nr - 1][j] = BLUE;
      model;
      drive_frame(-1, k % 2 == 1);
      frame_end;
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/lpr_boundary_detect.md
LPR_BOUNDARY_DETECT -- requirements
Module: lpr_boundary_detect

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  B_MIN, 100, minimum blue component for a candidate pixel
  DIFF_MIN, 40, minimum (B-R) and (B-G) for a candidate pixel
  ROW_MIN_CNT, 20, candidate pixels needed for a row to qualify
  MIN_HEIGHT, 8, minimum box height (vcount_r - vcount_l) for a valid box
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  pixelclk  in  1  sole clock
  reset  in  1  synchronous, active-high reset
  i_rgb  in  24  pixel, R=[23:16] G=[15:8] B=[7:0]
  i_hsync  in  1  line sync (unused except pass-through timing)
  i_vsync  in  1  frame sync, active-high
  i_de  in  1  active-video enable
  hcount  in  12  current pixel column
  vcount  in  12  current pixel row
  hcount_l / hcount_r  out  12  box left / right column
  vcount_l / vcount_r  out  12  box top / bottom row
  h2  out  12  box centre column
  v3 / v5  out  12  upper / lower inner guide rows
  box_valid  out  1  box found in last complete frame
  frame_done  out  1  one-cycle pulse when outputs update

Function
REQ-003 Candidate pixel SHALL be i_de=1 and B>=B_MIN and B>R and B>G and (B-R)>=DIFF_MIN and (B-G)>=DIFF_MIN; subtraction SHALL be unsigned 8-bit, evaluated only when B>R and B>G.
REQ-004 Per row: count candidates (12-bit, saturating at 4095), track min and max candidate hcount.
REQ-005 Row end SHALL be the i_de 1->0 transition; the row qualifies if count>=ROW_MIN_CNT; row registers SHALL clear on the cycle after row end.
REQ-006 On qualifying row: frame top=min(top,vcount of row), bottom=max(bottom,row), left=min(left,row min), right=max(right,row max); first qualifying row initialises all four.
REQ-007 Row end and a new candidate on the same cycle SHALL be impossible (i_de=0); a row end coinciding with frame end SHALL be merged before the frame update.
REQ-008 FSM states: IDLE (await first i_vsync 0->1), SCAN (accumulate), MERGE (one cycle, apply pending row), PUBLISH (one cycle, write outputs), then SCAN with frame accumulators cleared.
REQ-009 Frame end SHALL be the i_vsync 0->1 transition; from IDLE it only enters SCAN; from SCAN it goes to MERGE.
REQ-010 PUBLISH: if any row qualified and (bottom-top)>=MIN_HEIGHT, outputs SHALL take left/right/top/bottom, h2=(left+right)>>1 (13-bit sum), v3=top+((bottom-top)>>2), v5=bottom-((bottom-top)>>2), box_valid=1; else all coordinate outputs 0, box_valid=0.
REQ-011 Outputs SHALL change only in PUBLISH and be held otherwise; frame_done SHALL be high exactly in the PUBLISH cycle, i.e. 2 cycles after the registered vsync edge.
REQ-012 Pixels arriving during MERGE/PUBLISH SHALL be ignored (vsync blanking guarantees none).

Reset
REQ-013 reset sampled high on a pixelclk edge SHALL force IDLE, clear row/frame accumulators and edge-detect registers, set all coordinate outputs to 0, box_valid=0, frame_done=0.
REQ-014 Reset mid-frame SHALL discard the partial frame; first published frame SHALL be the first complete frame after the next vsync rising edge.

Structure
REQ-015 Package lpr_pkg SHALL hold the FSM state type, coordinate width (12) and parameter defaults.
REQ-016 Per-row count/min/max logic SHALL be sub-module lpr_row_accum.

Verification
REQ-017 640x480 frame, blue (R=20,G=30,B=200) rect cols 200-359, rows 300-339, black elsewhere -> hcount_l=200, hcount_r=359, vcount_l=300, vcount_r=339, h2=279, v3=309, v5=330, box_valid=1, frame_done 2 cycles after vsync rise.
REQ-018 All-black frame after REQ-017 frame -> all coordinates 0, box_valid=0.
REQ-019 Blue rows 300-304 only (height 4<8) -> box_valid=0, coordinates 0.
REQ-020 Row with 19 candidates (one short) among qualifying rows -> that row excluded from min/max; row with exactly 20 included.
REQ-021 Candidate pixel B=200,R=160 (diff 40) accepted; R=161 rejected; B=99 rejected.
REQ-022 reset asserted at row 320 of REQ-017 frame -> outputs 0 immediately after reset edge; no publish at next vsync; following full frame publishes REQ-017 values.
